// File: rtl/router_pkg.sv
// router_pkg -- constants shared by the router register block.
//
// Contents:
//   DATA_W_DEF    default packet byte width
//   ADDR_MSB/LSB  location of the destination address field in the header byte
//   ADDR_INVALID  address code that is not mapped to any output port
//   addr_t        type of the address field
//   addr_is_valid helper returning 1 when an address selects a real port
package router_pkg;

  localparam int DATA_W_DEF = 8;

  localparam int ADDR_MSB = 1;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_INVALID = 2'b11;

  function automatic logic addr_is_valid(input addr_t addr);
    return addr != ADDR_INVALID;
  endfunction

endpackage

// File: rtl/router_reg_parity.sv
// router_reg_parity -- parity accumulate / capture / compare for one packet.
//
// Ports:
//   clock, resetn          clock and synchronous active-low reset
//   detect_add             start of packet: clears both parity registers and err
//   lfd_state              header is being loaded: header_byte enters the parity
//   ld_state               payload/parity phase
//   full_state             output FIFO full: payload byte already accounted for
//   pkt_valid              high on header/payload, low on the parity byte
//   data_in                incoming byte
//   header_byte            latched header byte from the byte path
//   parity_done            parity byte has been received (compare enable)
//   err                    parity mismatch flag
//
// Build option ROUTER_REG_ERR_STICKY_EN:
//   defined   -> err stays high from the first mismatch until detect_add/reset
//   undefined -> err is a single-cycle pulse one clock after the compare
module router_reg_parity
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              full_state,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] header_byte,
  input  logic              parity_done,
  output logic              err
);

  logic [DATA_W-1:0] internal_parity_reg;
  logic [DATA_W-1:0] packet_parity_reg;
  logic              err_reg;
  logic              mismatch;

  assign mismatch = (internal_parity_reg != packet_parity_reg);
  assign err      = err_reg;

  // Running XOR of header and payload. A byte that arrives while the FIFO is
  // full is still counted in ld_state; the repeat presentation of that same
  // byte during full_state must not be counted a second time.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      internal_parity_reg <= '0;
      packet_parity_reg   <= '0;
    end else begin
      if (detect_add)
        internal_parity_reg <= '0;
      else if (lfd_state)
        internal_parity_reg <= internal_parity_reg ^ header_byte;
      else if (ld_state && pkt_valid && !full_state)
        internal_parity_reg <= internal_parity_reg ^ data_in;

      if (detect_add)
        packet_parity_reg <= '0;
      else if (ld_state && !pkt_valid)
        packet_parity_reg <= data_in;
    end
  end

`ifdef ROUTER_REG_ERR_STICKY_EN
  // Sticky flag: any compare cycle with a mismatch latches err.
  always_ff @(posedge clock) begin
    if (!resetn)
      err_reg <= 1'b0;
    else if (detect_add)
      err_reg <= 1'b0;
    else if (parity_done && mismatch)
      err_reg <= 1'b1;
  end
`else
  // Pulse flag: parity_done stays high until the next header, so the compare
  // is qualified with the first cycle of parity_done to give exactly one
  // clock of err per bad packet.
  logic parity_done_d_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      err_reg           <= 1'b0;
      parity_done_d_reg <= 1'b0;
    end else begin
      parity_done_d_reg <= parity_done;
      if (detect_add)
        err_reg <= 1'b0;
      else
        err_reg <= parity_done && !parity_done_d_reg && mismatch;
    end
  end
`endif

endmodule

// File: rtl/router_reg.sv
// router_reg -- byte path and status registers of the packet router.
//
// Ports:
//   clock, resetn          clock and synchronous active-low reset
//   pkt_valid              source packet-valid (low on the parity byte)
//   data_in   [DATA_W]     source packet byte; header address in [1:0]
//   fifo_full              full flag of the addressed output FIFO
//   detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg
//                          one-hot state decodes from the router FSM
//   dout      [DATA_W]     byte presented to the output FIFOs
//   parity_done            parity byte received and forwarded
//   low_pkt_valid          pkt_valid fell while loading data
//   err                    packet parity mismatch
//
// Build option ROUTER_REG_ERR_STICKY_EN selects sticky err (see
// router_reg_parity); default build produces a one-clock err pulse.
module router_reg
  import router_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] data_in,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              parity_done,
  output logic              low_pkt_valid,
  output logic              err
);

  logic [DATA_W-1:0] header_byte_reg;
  logic [DATA_W-1:0] fifo_full_byte_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              parity_done_reg;
  logic              low_pkt_valid_reg;
  logic              header_ok;

  assign header_ok     = addr_is_valid(data_in[ADDR_MSB:ADDR_LSB]);
  assign dout          = dout_reg;
  assign parity_done   = parity_done_reg;
  assign low_pkt_valid = low_pkt_valid_reg;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      header_byte_reg    <= '0;
      fifo_full_byte_reg <= '0;
      dout_reg           <= '0;
      parity_done_reg    <= 1'b0;
      low_pkt_valid_reg  <= 1'b0;
    end else begin
      // Headers addressed to the unmapped port are dropped here.
      if (detect_add && pkt_valid && header_ok)
        header_byte_reg <= data_in;

      // A byte arriving while the FIFO is full is parked and replayed in
      // laf_state; dout simply holds during the stall.
      if (ld_state && fifo_full)
        fifo_full_byte_reg <= data_in;

      if (lfd_state)
        dout_reg <= header_byte_reg;
      else if (ld_state && !fifo_full)
        dout_reg <= data_in;
      else if (laf_state)
        dout_reg <= fifo_full_byte_reg;

      // Set has priority over the FSM's internal-reset clear.
      if (ld_state && !pkt_valid)
        low_pkt_valid_reg <= 1'b1;
      else if (rst_int_reg)
        low_pkt_valid_reg <= 1'b0;

      // Parity byte forwarded directly, or replayed after a full stall.
      if (detect_add)
        parity_done_reg <= 1'b0;
      else if ((ld_state && !fifo_full && !pkt_valid) ||
               (laf_state && low_pkt_valid_reg && !parity_done_reg))
        parity_done_reg <= 1'b1;
    end
  end

  router_reg_parity #(
    .DATA_W (DATA_W)
  ) u_parity (
    .clock       (clock),
    .resetn      (resetn),
    .detect_add  (detect_add),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .full_state  (full_state),
    .pkt_valid   (pkt_valid),
    .data_in     (data_in),
    .header_byte (header_byte_reg),
    .parity_done (parity_done_reg),
    .err         (err)
  );

endmodule

// File: tb/tb_router_reg.sv
// tb_router_reg -- self-checking bench for router_reg.
// Expected dout bytes are queued as each FSM step is driven and popped after
// the clock edge that should produce them.
module tb_router_reg;

  localparam logic [5:0] S_IDLE = 6'b000000;
  localparam logic [5:0] S_DET  = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  logic       clock = 1'b0;
  logic       resetn;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [7:0] dout;
  logic       parity_done, low_pkt_valid, err;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  router_reg #(.DATA_W(8)) dut (
    .clock         (clock),
    .resetn        (resetn),
    .pkt_valid     (pkt_valid),
    .data_in       (data_in),
    .fifo_full     (fifo_full),
    .detect_add    (detect_add),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid),
    .err           (err)
  );

  always #5 clock = ~clock;

  // Drive one FSM step, then sample 1 time unit after the edge.
  task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    pkt_valid = pv;
    data_in   = d;
    fifo_full = ff;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(S_IDLE, 1'b0, 8'hFF, 1'b0);
    cyc(S_IDLE, 1'b0, 8'hFF, 1'b0);
    checks += 4;
    if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", dout); end
    if (parity_done !== 1'b0) begin errors++; $display("FAIL reset_parity_done: got %b expected 0", parity_done); end
    if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_low_pkt_valid: got %b expected 0", low_pkt_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    resetn = 1'b1;
    $display("test_reset: dout=%h parity_done=%b low_pkt_valid=%b err=%b", dout, parity_done, low_pkt_valid, err);
  endtask

  task automatic test_normal(input string tag, input logic [7:0] par, input logic exp_err);
    logic [5:0] st [5];
    logic       pv [5];
    logic [7:0] dd [5];
    logic [7:0] exp;
    st = '{S_DET, S_LFD, S_LD, S_LD, S_LD};
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dd = '{8'h05, 8'h11, 8'h11, 8'h22, par};
    for (int i = 0; i < 5; i++) begin
      if (i == 1) exp_q.push_back(8'h05);
      else if (i > 1) exp_q.push_back(dd[i]);
      cyc(st[i], pv[i], dd[i], 1'b0);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL %s_dout[%0d]: got %h expected %h", tag, i, dout, exp); end
      end
    end
    checks += 2;
    if (parity_done !== 1'b1) begin errors++; $display("FAIL %s_parity_done: got %b expected 1", tag, parity_done); end
    if (err !== 1'b0) begin errors++; $display("FAIL %s_err_early: got %b expected 0", tag, err); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    checks += 2;
    if (err !== exp_err) begin errors++; $display("FAIL %s_err: got %b expected %b", tag, err, exp_err); end
    if (parity_done !== 1'b1) begin errors++; $display("FAIL %s_parity_done_hold: got %b expected 1", tag, parity_done); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    checks++;
`ifdef ROUTER_REG_ERR_STICKY_EN
    if (err !== exp_err) begin errors++; $display("FAIL %s_err_after: got %b expected %b", tag, err, exp_err); end
`else
    if (err !== 1'b0) begin errors++; $display("FAIL %s_err_after: got %b expected 0", tag, err); end
`endif
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    $display("%s: header 05 payload 11 22 parity %h -> dout=%h parity_done=%b err=%b", tag, par, dout, parity_done, err);
  endtask

  task automatic test_full_stall();
    logic [5:0] st [7];
    logic       pv [7];
    logic [7:0] dd [7];
    logic       ff [7];
    logic [7:0] ex [7];
    logic [7:0] exp;
    st = '{S_DET, S_LFD, S_LD, S_FULL, S_LAF, S_LD, S_LD};
    pv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    dd = '{8'h06, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h5A, 8'hF9};
    ff = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ex = '{8'h00, 8'h06, 8'h06, 8'h06, 8'hA5, 8'h5A, 8'hF9};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) exp_q.push_back(ex[i]);
      cyc(st[i], pv[i], dd[i], ff[i]);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL full_dout[%0d]: got %h expected %h", i, dout, exp); end
      end
    end
    checks += 2;
    if (parity_done !== 1'b1) begin errors++; $display("FAIL full_parity_done: got %b expected 1", parity_done); end
    if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL full_low_pkt_valid: got %b expected 1", low_pkt_valid); end
    cyc(S_IDLE, 1'b0, 8'h00, 1'b0);
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b expected 0", err); end
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    $display("test_full_stall: stalled A5 replayed, final dout=%h err=%b", dout, err);
  endtask

  task automatic test_late_end();
    logic [5:0] st [6];
    logic       pv [6];
    logic [7:0] dd [6];
    logic       ff [6];
    logic [7:0] ex [6];
    logic [7:0] exp;
    st = '{S_DET, S_LFD, S_LD, S_LD, S_FULL, S_LAF};
    pv = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    dd = '{8'h09, 8'h33, 8'h33, 8'h3A, 8'h3A, 8'h3A};
    ff = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    ex = '{8'h00, 8'h09, 8'h33, 8'h33, 8'h33, 8'h3A};
    for (int i = 0; i < 6; i++) begin
      if (i > 0) exp_q.push_back(ex[i]);
      cyc(st[i], pv[i], dd[i], ff[i]);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (dout !== exp) begin errors++; $display("FAIL late_dout[%0d]: got %h expected %h", i, dout, exp); end
      end
      if (i == 3) begin
        checks += 2;
        if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL late_low_set: got %b expected 1", low_pkt_valid); end
        if (parity_done !== 1'b0) begin errors++; $display("FAIL late_pd_blocked: got %b expected 0", parity_done); end
      end
    end
    checks++;
    if (parity_done !== 1'b1) begin errors++; $display("FAIL late_pd_laf: got %b expected 1", parity_done); end
    cyc(S_RST, 1'b0, 8'h3A, 1'b0);
    checks += 2;
    if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL late_low_clear: got %b expected 0", low_pkt_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL late_err: got %b expected 0", err); end
    // Set and clear in the same cycle: set must win.
    cyc(S_LD | S_RST, 1'b0, 8'h3A, 1'b1);
    checks++;
    if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL late_set_wins: got %b expected 1", low_pkt_valid); end
    cyc(S_RST, 1'b0, 8'h3A, 1'b0);
    $display("test_late_end: parity via laf, dout=%h low_pkt_valid=%b", dout, low_pkt_valid);
  endtask

  task automatic test_invalid_addr();
    cyc(S_DET, 1'b1, 8'h07, 1'b0);
    checks += 2;
    if (dout !== 8'h3A) begin errors++; $display("FAIL inv_dout_hold: got %h expected 3A", dout); end
    if (parity_done !== 1'b0) begin errors++; $display("FAIL inv_pd_clear: got %b expected 0", parity_done); end
    exp_q.push_back(8'h09);
    cyc(S_LFD, 1'b1, 8'h07, 1'b0);
    begin
      logic [7:0] exp;
      exp = exp_q.pop_front();
      checks++;
      if (dout !== exp) begin errors++; $display("FAIL inv_header_kept: got %h expected %h", dout, exp); end
    end
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    $display("test_invalid_addr: header 07 ignored, lfd dout=%h", dout);
  endtask

  task automatic test_reset_mid();
    cyc(S_DET, 1'b1, 8'h0D, 1'b0);
    cyc(S_LFD, 1'b1, 8'h44, 1'b0);
    cyc(S_LD, 1'b1, 8'h44, 1'b0);
    cyc(S_LD, 1'b0, 8'hFF, 1'b0);
    checks += 3;
    if (dout !== 8'hFF) begin errors++; $display("FAIL rmid_pre_dout: got %h expected FF", dout); end
    if (parity_done !== 1'b1) begin errors++; $display("FAIL rmid_pre_pd: got %b expected 1", parity_done); end
    if (low_pkt_valid !== 1'b1) begin errors++; $display("FAIL rmid_pre_low: got %b expected 1", low_pkt_valid); end
    resetn = 1'b0;
    cyc(S_LD, 1'b1, 8'hAA, 1'b0);
    resetn = 1'b1;
    checks += 4;
    if (dout !== 8'h00) begin errors++; $display("FAIL rmid_dout: got %h expected 00", dout); end
    if (parity_done !== 1'b0) begin errors++; $display("FAIL rmid_pd: got %b expected 0", parity_done); end
    if (low_pkt_valid !== 1'b0) begin errors++; $display("FAIL rmid_low: got %b expected 0", low_pkt_valid); end
    if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %b expected 0", err); end
    // header_byte must have been cleared too.
    cyc(S_LFD, 1'b0, 8'h00, 1'b0);
    checks++;
    if (dout !== 8'h00) begin errors++; $display("FAIL rmid_header_cleared: got %h expected 00", dout); end
    $display("test_reset_mid: outputs cleared, dout=%h", dout);
    test_normal("after_reset", 8'h36, 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_IDLE;
    pkt_valid = 1'b0;
    data_in   = 8'h00;
    fifo_full = 1'b0;
    test_reset();
    test_normal("normal", 8'h36, 1'b0);
    test_normal("bad_parity", 8'h00, 1'b1);
    test_full_stall();
    test_late_end();
    test_invalid_addr();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
